// File: rtl/fixed_point_divider.sv
// Iterative unsigned Q(WIDTH-FBITS).FBITS divider: quotient = (dividend << FBITS) / divisor,
// one restoring radix-2 quotient bit per clock, with a one-cycle ready pulse on completion.
module fixed_point_divider #(
  parameter int WIDTH = 32,
  parameter int FBITS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             ready,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int N  = WIDTH + FBITS;
  localparam int CW = $clog2(N + 1);
  localparam int PW = WIDTH + 1;

  typedef enum logic [0:0] {IDLE, CALC} state_e;

  state_e           state_q,     state_d;
  logic [N-1:0]     shreg_q,     shreg_d;
  logic [N-1:0]     acc_q,       acc_d;
  logic [PW-1:0]    prem_q,      prem_d;
  logic [WIDTH-1:0] dvsr_q,      dvsr_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic [WIDTH-1:0] quotient_q,  quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             busy_q,      busy_d;
  logic             ready_q,     ready_d;
  logic             dbz_q,       dbz_d;
  logic             ovf_q,       ovf_d;

  // Trial-subtraction datapath, evaluated every cycle and used only in CALC.
  logic [PW:0] shifted;
  logic [PW:0] dvsr_ext;
  logic        qbit;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d     = state_q;
    shreg_d     = shreg_q;
    acc_d       = acc_q;
    prem_d      = prem_q;
    dvsr_d      = dvsr_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    ready_d     = 1'b0;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;

    shifted  = {prem_q, shreg_q[N-1]};
    dvsr_ext = {2'b00, dvsr_q};
    qbit     = (shifted >= dvsr_ext);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = '0;
            dbz_d       = 1'b1;
            ovf_d       = 1'b0;
            ready_d     = 1'b1;
          end else begin
            shreg_d = {dividend, {FBITS{1'b0}}};
            acc_d   = '0;
            prem_d  = '0;
            dvsr_d  = divisor;
            cnt_d   = CW'(N);
            busy_d  = 1'b1;
            dbz_d   = 1'b0;
            ovf_d   = 1'b0;
            state_d = CALC;
          end
        end
      end

      CALC: begin
        // The partial remainder stays below the divisor, so the restored value fits PW bits.
        prem_d  = qbit ? PW'(shifted - dvsr_ext) : PW'(shifted);
        acc_d   = {acc_q[N-2:0], qbit};
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          ovf_d       = |acc_d[N-1:WIDTH];
          quotient_d  = ovf_d ? '1 : acc_d[WIDTH-1:0];
          remainder_d = prem_d[WIDTH-1:0];
          busy_d      = 1'b0;
          ready_d     = 1'b1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      acc_q       <= '0;
      prem_q      <= '0;
      dvsr_q      <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      acc_q       <= acc_d;
      prem_q      <= prem_d;
      dvsr_q      <= dvsr_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign ready       = ready_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: doc/fixed_point_divider.md
Name: fixed_point_divider

Overview:
- Iterative unsigned fixed-point divider, the inverse operation of the FPU's sequential multiplier. Operand format Q(WIDTH-FBITS).FBITS.
- Computes quotient = (dividend << FBITS) / divisor, one quotient bit per clock (radix-2 restoring).
- Sits beside the fixed-point unit, driven by the same operand buses; reports completion with a one-cycle ready pulse.

Parameters:
- WIDTH, 32, operand/result width in bits
- FBITS, 10, fractional bits in the fixed-point format
- N (localparam), WIDTH+FBITS, iteration count (42 at defaults)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on posedge clk only while idle
- dividend  input  WIDTH  numerator, fixed-point
- divisor  input  WIDTH  denominator, fixed-point
- quotient  output  WIDTH  result, fixed-point, truncated toward zero
- remainder  output  WIDTH  (dividend<<FBITS) mod divisor
- busy  output  1  high while iterating
- ready  output  1  one-cycle completion pulse
- div_by_zero  output  1  last accepted op had divisor==0
- overflow  output  1  last accepted op's quotient exceeded WIDTH bits

Behaviour:
- Reset: clk is Already decided; reset reset, asynchronous, active-high; clock clk. While reset is asserted, quotient, remainder, busy, ready, div_by_zero and overflow are 0, state is IDLE, and the iteration counter and working registers are 0.
- States: IDLE, CALC. No other state. Unreachable encodings go to IDLE.
- IDLE, start=1, divisor!=0 (edge E0):
  - Latch {dividend, FBITS zeros} into an N-bit shift register, the partial remainder into a WIDTH+1-bit register set to 0, and the counter to N.
  - Set busy=1, clear div_by_zero and overflow, and go to CALC.
- IDLE, start=1, divisor==0 (edge E0):
  - quotient=all ones, remainder=0, div_by_zero=1, overflow=0.
  - ready=1 for exactly one cycle; stay IDLE; busy stays 0.
- CALC, each edge:
  - Shift the MSB of the shift register into the partial remainder.
  - Trial subtract divisor. If non-negative, keep the difference and shift 1 into the quotient accumulator; otherwise keep the old value and shift 0.
  - Decrement the counter.
- Completion at the edge where the counter goes 1->0 (edge E0+N):
  - quotient = low WIDTH bits of the N-bit accumulator; remainder = final partial remainder.
  - If the upper FBITS bits of the accumulator are nonzero: overflow=1, quotient saturates to all ones, remainder still reports the true remainder.
  - busy=0, ready=1, go to IDLE.
- ready is high for exactly one cycle and is cleared at the next edge.
- Latency, start edge to ready-high edge: N cycles (42 at defaults), or 1 cycle for divide-by-zero.
- Back-to-back: a start seen in the same cycle ready is high is accepted, because state is already IDLE.
- start while busy is ignored; no queuing, and the running operation is unaffected.
- dividend/divisor are sampled only at acceptance; later changes have no effect.
- quotient, remainder, div_by_zero and overflow hold their values until the next accepted start or reset.
- Reset mid-CALC aborts immediately to reset values, and no ready pulse is produced.
- All arithmetic is unsigned. No rounding: the result is truncated.

Test Plan:
- 3.0/2.0: dividend=0x00000C00, divisor=0x00000800, pulse start -> after 42 cycles ready pulses once, quotient=0x00000600, remainder=0, overflow=0, div_by_zero=0; busy high for those 42 cycles.
- 1.0/3.0: dividend=0x00000400, divisor=0x00000C00 -> quotient=0x00000155, remainder=0x00000400, ready at cycle 42.
- Divide by zero: dividend=0x00001000, divisor=0 -> next cycle ready=1, quotient=0xFFFFFFFF, div_by_zero=1, busy never asserted; a following 3.0/2.0 op clears div_by_zero.
- Overflow: dividend=0xFFFFFFFF, divisor=0x00000001 -> at cycle 42 overflow=1, quotient=0xFFFFFFFF, remainder=0.
- Start while busy: start 3.0/2.0, then at cycle 10 change the operands to 1.0/3.0 and pulse start -> one ready only, at cycle 42, quotient=0x00000600. Then start 1.0/3.0 in the ready cycle -> accepted, and its result is ready 42 cycles later.
- Reset mid-op: assert reset asynchronously at cycle 20 of a divide -> all outputs 0 immediately, no ready pulse. After release, a new 3.0/2.0 completes correctly in 42 cycles.
